risc_toy_mem_arbiter: RTL

//  Shares one single-port memory between the RISC_TOY instruction-fetch port (I) and data port (D).
//  Non-pipelined: at most one memory access is outstanding at a time.
//  D normally wins ties; a starvation counter guarantees I forward progress.

---
 rtl/risc_toy_mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/risc_toy_mem_arbiter.sv
// risc_toy_mem_arbiter
// Shares one single-port memory between the RISC_TOY fetch port (I) and data
// port (D). Only one access is in flight at a time. D wins ties, but a
// starvation counter hands the memory to I after MAX_DBURST consecutive D
// grants made while I was waiting. Every output comes straight from a flop.
module risc_toy_mem_arbiter #(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_DBURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    // instruction-fetch side
    input  logic          IREQ,
    input  logic [AW-1:0] IADDR,
    output logic          IACK,
    output logic [DW-1:0] IRDATA,
    // data side
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic          DACK,
    output logic [DW-1:0] DRDATA,
    // unified memory side
    output logic          MREQ,
    output logic          MRW,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic [DW-1:0] MRDATA,
    // status
    output logic          BUSY
);

    // Starvation counter must be able to hold MAX_DBURST itself.
    localparam int SW = $clog2(MAX_DBURST + 1);
    // Wait counter holds MEM_LAT-1; keep at least one bit for MEM_LAT==1.
    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [SW-1:0] STARV_MAX = SW'(MAX_DBURST);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic            owner_i_q,   owner_i_d;    // 1: I owns the access, 0: D
    logic [WW-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [SW-1:0]   starv_cnt_q, starv_cnt_d;

    // The memory-side registers double as the address/rw/wdata latches:
    // they are loaded on grant and simply hold until the next grant.
    logic            mreq_q,      mreq_d;
    logic            mrw_q,       mrw_d;
    logic [AW-1:0]   maddr_q,     maddr_d;
    logic [DW-1:0]   mwdata_q,    mwdata_d;

    logic            iack_q,      iack_d;
    logic            dack_q,      dack_d;
    logic [DW-1:0]   irdata_q,    irdata_d;
    logic [DW-1:0]   drdata_q,    drdata_d;
    logic            busy_q,      busy_d;

    // D wins unless I is also waiting and D has used up its burst allowance.
    logic grant_d_side;
    always_comb begin
        grant_d_side = DREQ && (!IREQ || (starv_cnt_q != STARV_MAX));
    end

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        owner_i_d   = owner_i_q;
        wait_cnt_d  = wait_cnt_q;
        starv_cnt_d = starv_cnt_q;
        mreq_d      = 1'b0;
        mrw_d       = mrw_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        iack_d      = 1'b0;
        dack_d      = 1'b0;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (IREQ || DREQ) begin
                    // Loading the memory registers here makes MREQ and the
                    // payload appear together in the ISSUE cycle.
                    mreq_d  = 1'b1;
                    state_d = ST_ISSUE;
                    if (grant_d_side) begin
                        owner_i_d = 1'b0;
                        maddr_d   = DADDR;
                        mrw_d     = DRW;
                        mwdata_d  = DWDATA;
                        if (IREQ) begin
                            if (starv_cnt_q != STARV_MAX) begin
                                starv_cnt_d = starv_cnt_q + SW'(1);
                            end
                        end else begin
                            starv_cnt_d = '0;
                        end
                    end else begin
                        // Fetches are always reads; write data keeps its
                        // previous value.
                        owner_i_d   = 1'b1;
                        maddr_d     = IADDR;
                        mrw_d       = 1'b0;
                        starv_cnt_d = '0;
                    end
                end
            end

            ST_ISSUE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end else begin
                    // MRDATA is valid in this cycle; capture it so it is
                    // presented alongside the ACK pulse.
                    if (owner_i_q) begin
                        irdata_d = MRDATA;
                        iack_d   = 1'b1;
                    end else begin
                        if (!mrw_q) begin
                            drdata_d = MRDATA;
                        end
                        dack_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // BUSY is registered from the next state so it tracks the FSM exactly.
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            owner_i_q   <= 1'b0;
            wait_cnt_q  <= '0;
            starv_cnt_q <= '0;
            mreq_q      <= 1'b0;
            mrw_q       <= 1'b0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            iack_q      <= 1'b0;
            dack_q      <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_i_q   <= owner_i_d;
            wait_cnt_q  <= wait_cnt_d;
            starv_cnt_q <= starv_cnt_d;
            mreq_q      <= mreq_d;
            mrw_q       <= mrw_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            iack_q      <= iack_d;
            dack_q      <= dack_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            busy_q      <= busy_d;
        end
    end

    assign MREQ   = mreq_q;
    assign MRW    = mrw_q;
    assign MADDR  = maddr_q;
    assign MWDATA = mwdata_q;
    assign IACK   = iack_q;
    assign IRDATA = irdata_q;
    assign DACK   = dack_q;
    assign DRDATA = drdata_q;
    assign BUSY   = busy_q;

endmodule
